// File: rtl/debug_pkg.sv
// debug_pkg: shared state encoding and counter widths for the debug step controller.
package debug_pkg;

    typedef enum logic [1:0] {
        DBG_RUN,
        DBG_HALT,
        DBG_STEP
    } dbg_state_t;

    localparam int unsigned STEP_COUNT_W = 16;

    // Width of the per-step cpu_en cycle counter for a given step length.
    function automatic int unsigned step_cnt_w(input int unsigned step_cycles);
        return $clog2(step_cycles + 1);
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: synchronises one asynchronous input and only forwards a new level
// once it has persisted for DEBOUNCE_CYCLES consecutive cycles.
module input_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic stable_out
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_stable;
    logic                   w_sync;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign stable_out = r_stable;

    // Metastability chain, reset to the input's inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
        end
    end

    // Count consecutive disagreeing samples; adopt the new level on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_stable <= RST_VAL;
        end else if (w_sync == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt    <= '0;
            r_stable <= w_sync;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/debug_step_ctrl.sv
// debug_step_ctrl: debug switch / step key front end producing the CPU clock-enable.
// Optional feature: define AUTO_STEP_EN to auto-repeat steps while the key is held.
module debug_step_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned STEP_CYCLES     = 1,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_step_n,
    input  logic                    sw_debug,
    output logic                    debug,
    output logic                    cpu_en,
    output logic [STEP_COUNT_W-1:0] step_count
);

    localparam int unsigned STEP_CNT_W = step_cnt_w(STEP_CYCLES);

    // Reject configurations the counters cannot represent.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || STEP_CYCLES < 1 ||
        HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("debug_step_ctrl: invalid parameter set");
    end

    dbg_state_t              r_state;
    logic                    r_debug;
    logic                    r_cpu_en;
    logic [STEP_CNT_W-1:0]   r_step_cnt;
    logic [STEP_COUNT_W-1:0] r_step_count;
    logic                    r_key_prev;
    logic                    w_sw_stable;
    logic                    w_key_stable;
    logic                    w_press;
    logic                    w_step_req;

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (1'b0)
    ) u_sw_db (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (sw_debug),
        .stable_out(w_sw_stable)
    );

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (1'b1)
    ) u_key_db (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (key_step_n),
        .stable_out(w_key_stable)
    );

    // Remember the previous debounced key level to find the press edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_prev <= 1'b1;
        end else begin
            r_key_prev <= w_key_stable;
        end
    end

    assign w_press = r_key_prev & ~w_key_stable;

`ifdef AUTO_STEP_EN
    localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    logic              r_hold_on;
    logic              r_repeating;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_hold_hit;
    logic              w_rep_req;

    assign w_hold_hit = r_repeating ? (r_hold_cnt == HOLD_W'(REPEAT_CYCLES))
                                    : (r_hold_cnt == HOLD_W'(HOLD_CYCLES));
    assign w_rep_req  = r_hold_on & ~w_key_stable & w_hold_hit;
    assign w_step_req = w_press | w_rep_req;

    // Hold timer: armed by a press in HALT, first repeat after HOLD, then every REPEAT.
    always_ff @(posedge clk) begin
        if (rst || w_key_stable || r_state == DBG_RUN) begin
            r_hold_on   <= 1'b0;
            r_repeating <= 1'b0;
            r_hold_cnt  <= '0;
        end else if (w_press && r_state == DBG_HALT) begin
            r_hold_on   <= 1'b1;
            r_repeating <= 1'b0;
            r_hold_cnt  <= HOLD_W'(1);
        end else if (r_hold_on) begin
            if (w_hold_hit) begin
                r_repeating <= 1'b1;
                r_hold_cnt  <= HOLD_W'(1);
            end else begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
        end
    end
`else
    assign w_step_req = w_press;
`endif

    // RUN/HALT/STEP sequencer; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= DBG_RUN;
            r_debug      <= 1'b0;
            r_cpu_en     <= 1'b1;
            r_step_cnt   <= '0;
            r_step_count <= '0;
        end else begin
            unique case (r_state)
                DBG_RUN: begin
                    if (w_sw_stable) begin
                        r_state      <= DBG_HALT;
                        r_debug      <= 1'b1;
                        r_cpu_en     <= 1'b0;
                        r_step_count <= '0;
                    end
                end
                DBG_HALT: begin
                    if (!w_sw_stable) begin
                        r_state  <= DBG_RUN;
                        r_debug  <= 1'b0;
                        r_cpu_en <= 1'b1;
                    end else if (w_step_req) begin
                        r_state      <= DBG_STEP;
                        r_cpu_en     <= 1'b1;
                        r_step_cnt   <= STEP_CNT_W'(STEP_CYCLES - 1);
                        r_step_count <= r_step_count + STEP_COUNT_W'(1);
                    end
                end
                DBG_STEP: begin
                    if (r_step_cnt == '0) begin
                        r_state  <= DBG_HALT;
                        r_cpu_en <= 1'b0;
                    end else begin
                        r_step_cnt <= r_step_cnt - STEP_CNT_W'(1);
                    end
                end
                default: begin
                    r_state  <= DBG_RUN;
                    r_debug  <= 1'b0;
                    r_cpu_en <= 1'b1;
                end
            endcase
        end
    end

    assign debug      = r_debug;
    assign cpu_en     = r_cpu_en;
    assign step_count = r_step_count;

endmodule
